fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard controller for the MIPS150 datapath.
- Supersedes the fixed one-instruction-back forwarding in Control, which compares only the current and previous instruction.
- Tracks the destination registers of the last DEPTH issued instructions in a shift pipeline.
- Produces per-operand forwarding selects, a load-use stall and flush handling; sits beside Control and drives the ALU operand muxes.

---
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use stall controller tracking the last DEPTH writeback destinations.
// Optional StallCount output when FWD_STALL_COUNT_EN is defined.
module fwd_hazard_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned SEL_W    = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              IssueValid,
    input  logic [REG_AW-1:0] IssueRs,
    input  logic [REG_AW-1:0] IssueRt,
    input  logic              IssueUsesRt,
    input  logic [REG_AW-1:0] IssueDst,
    input  logic              IssueWrites,
    input  logic              IssueIsLoad,
    input  logic              Flush,
    output logic              Stall,
    output logic [SEL_W-1:0]  FwdSelA,
    output logic [SEL_W-1:0]  FwdSelB,
    output logic              PipeBusy
`ifdef FWD_STALL_COUNT_EN
    ,
    output logic [31:0]       StallCount
`endif
);

    logic [DEPTH:1]    v_q, v_d;
    logic [DEPTH:1]    ld_q, ld_d;
    logic [REG_AW-1:0] dst_q [1:DEPTH];
    logic [REG_AW-1:0] dst_d [1:DEPTH];

    logic [SEL_W-1:0]  sel_a, sel_b;
    logic              haz_a, haz_b;
    logic              push;

    // Scan oldest to youngest so the youngest matching entry overwrites older ones.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (v_q[DEPTH-i] && dst_q[DEPTH-i] == IssueRs && IssueRs != '0) begin
                sel_a = SEL_W'(DEPTH - i);
                haz_a = ld_q[DEPTH-i] && ((DEPTH - i) <= LOAD_LAT);
            end
            if (v_q[DEPTH-i] && dst_q[DEPTH-i] == IssueRt && IssueRt != '0) begin
                sel_b = SEL_W'(DEPTH - i);
                haz_b = ld_q[DEPTH-i] && ((DEPTH - i) <= LOAD_LAT);
            end
        end
    end

    assign FwdSelA  = IssueValid ? sel_a : '0;
    assign FwdSelB  = (IssueValid && IssueUsesRt) ? sel_b : '0;
    assign Stall    = IssueValid && !Flush && (haz_a || (IssueUsesRt && haz_b));
    assign PipeBusy = |v_q;
    assign push     = IssueValid && IssueWrites && (IssueDst != '0) && !Stall && !Flush;

    always_comb begin
        v_d      = v_q;
        ld_d     = ld_q;
        dst_d    = dst_q;
        v_d[1]   = push;
        ld_d[1]  = IssueIsLoad;
        dst_d[1] = IssueDst;
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            v_d[k]   = v_q[k-1];
            ld_d[k]  = ld_q[k-1];
            dst_d[k] = dst_q[k-1];
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            v_q  <= '0;
            ld_q <= '0;
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                dst_q[k] <= '0;
            end
        end else begin
            v_q   <= v_d;
            ld_q  <= ld_d;
            dst_q <= dst_d;
        end
    end

`ifdef FWD_STALL_COUNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit (DEPTH=2, LOAD_LAT=1); covers StallCount when FWD_STALL_COUNT_EN is defined.
module tb_fwd_hazard_unit;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       IssueValid;
    logic [4:0] IssueRs, IssueRt, IssueDst;
    logic       IssueUsesRt, IssueWrites, IssueIsLoad, Flush;
    logic       Stall, PipeBusy;
    logic [2:0] FwdSelA, FwdSelB;
`ifdef FWD_STALL_COUNT_EN
    logic [31:0] StallCount;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] sb [$];

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses;
        logic [4:0] dst;
        logic       writes;
        logic       ld;
        logic       flush;
        logic [7:0] exp;
    } row_t;

    fwd_hazard_unit #(
        .DEPTH(2),
        .LOAD_LAT(1),
        .REG_AW(5),
        .SEL_W(3)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .IssueValid(IssueValid),
        .IssueRs(IssueRs),
        .IssueRt(IssueRt),
        .IssueUsesRt(IssueUsesRt),
        .IssueDst(IssueDst),
        .IssueWrites(IssueWrites),
        .IssueIsLoad(IssueIsLoad),
        .Flush(Flush),
        .Stall(Stall),
        .FwdSelA(FwdSelA),
        .FwdSelB(FwdSelB),
        .PipeBusy(PipeBusy)
`ifdef FWD_STALL_COUNT_EN
        ,
        .StallCount(StallCount)
`endif
    );

    always #5 Clock = ~Clock;

    function automatic row_t mk(input logic rst, input logic valid, input int rs, input int rt,
                                input logic uses, input int dst, input logic writes, input logic ld,
                                input logic flush, input logic st, input int sa, input int sbv,
                                input logic busy);
        row_t r;
        r.rst    = rst;
        r.valid  = valid;
        r.rs     = 5'(rs);
        r.rt     = 5'(rt);
        r.uses   = uses;
        r.dst    = 5'(dst);
        r.writes = writes;
        r.ld     = ld;
        r.flush  = flush;
        r.exp    = {st, 3'(sa), 3'(sbv), busy};
        return r;
    endfunction

    task automatic drive(input row_t r);
        Reset       = r.rst;
        IssueValid  = r.valid;
        IssueRs     = r.rs;
        IssueRt     = r.rt;
        IssueUsesRt = r.uses;
        IssueDst    = r.dst;
        IssueWrites = r.writes;
        IssueIsLoad = r.ld;
        Flush       = r.flush;
    endtask

    task automatic test_reset();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 16, 0, 0, 17, 1, 0, 0, 0, 1, 0, 1));
        rows.push_back(mk(0, 1, 16, 0, 0, 16, 1, 0, 0, 0, 2, 0, 1));
        rows.push_back(mk(0, 1, 16, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 16, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_forward();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 1, 2, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 16, 16, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 1, 2, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 16, 16, 1, 0, 0, 0, 0, 0, 2, 2, 1));
        rows.push_back(mk(1, 1, 1, 2, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 16, 16, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 1, 2, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 16, 16, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 1, 2, 1, 16, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 0, 16, 16, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL forward row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 17, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 17, 1, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 17, 17, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 17, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 18, 1, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 1, 17, 18, 1, 0, 0, 0, 0, 0, 2, 1, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_load_use();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 18, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 18, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        rows.push_back(mk(1, 1, 18, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 20, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 20, 1, 0, 0, 0, 0, 1, 0, 1, 1));
        rows.push_back(mk(1, 1, 0, 20, 1, 0, 0, 0, 0, 0, 0, 2, 1));
        rows.push_back(mk(1, 1, 0, 0, 0, 21, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 21, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_use row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
`ifdef FWD_STALL_COUNT_EN
            if (i == 2) begin
                checks++;
                if (StallCount !== 32'd1) begin
                    errors++;
                    $display("FAIL stall_count_first: got %0d want 1", StallCount);
                end
            end
`endif
            @(posedge Clock); #1;
        end
`ifdef FWD_STALL_COUNT_EN
        checks++;
        if (StallCount !== 32'd2) begin
            errors++;
            $display("FAIL stall_count_total: got %0d want 2", StallCount);
        end
`endif
    endtask

    task automatic test_reg_zero();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reg_zero row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 19, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(1, 1, 19, 0, 0, 22, 1, 0, 1, 0, 1, 0, 1));
        rows.push_back(mk(1, 1, 22, 19, 1, 0, 0, 0, 0, 0, 0, 2, 1));
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL flush row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        row_t rows[$];
        logic [7:0] obs, exp;
        rows.push_back(mk(1, 1, 0, 0, 0, 18, 1, 1, 0, 0, 0, 0, 0));
        rows.push_back(mk(0, 1, 18, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1));
        rows.push_back(mk(1, 1, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (rows[i]) begin
            drive(rows[i]);
            sb.push_back(rows[i].exp);
            @(negedge Clock);
            obs = {Stall, FwdSelA, FwdSelB, PipeBusy};
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_stall row %0d: got {stall,selA,selB,busy}=%b want %b", i, obs, exp);
            end
            @(posedge Clock); #1;
        end
`ifdef FWD_STALL_COUNT_EN
        checks++;
        if (StallCount !== 32'd0) begin
            errors++;
            $display("FAIL stall_count_reset: got %0d want 0", StallCount);
        end
`endif
    endtask

    initial begin
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge Clock);
        #1;
        test_reset();
        test_forward();
        test_back_to_back();
        test_load_use();
        test_reg_zero();
        test_flush();
        test_reset_mid_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
